// File: rtl/wor_reg_table.sv
// Multi-port register table with two fields per entry, wired-OR read muxes,
// same-cycle write bypass, a sticky range-error flag and a one-entry-per-cycle clear sweep.
module wor_reg_table #(
  parameter int ENTRIES  = 32,
  parameter int IDX_W    = 5,
  parameter int A_W      = 5,
  parameter int B_W      = 16,
  parameter int RD_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic                       wr_a_en_i,
  input  logic                       wr_b_en_i,
  input  logic [A_W-1:0]             wr_a_i,
  input  logic [B_W-1:0]             wr_b_i,
  input  logic [RD_PORTS-1:0]        rd_en_i,
  input  logic [RD_PORTS*IDX_W-1:0]  rd_idx_i,
  output logic [RD_PORTS-1:0]        rd_valid_o,
  output logic [RD_PORTS*A_W-1:0]    rd_a_o,
  output logic [RD_PORTS*B_W-1:0]    rd_b_o,
  input  logic                       clr_req_i,
  output logic                       busy_o,
  output logic                       err_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [IDX_W:0]   ENT_L = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(ENTRIES - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [A_W-1:0]          a_q [ENTRIES];
  logic [A_W-1:0]          a_d [ENTRIES];
  logic [B_W-1:0]          b_q [ENTRIES];
  logic [B_W-1:0]          b_d [ENTRIES];
  logic                    err_q, err_d;
  logic [RD_PORTS-1:0]     vld_q, vld_d;
  logic [RD_PORTS*A_W-1:0] rda_q, rda_d;
  logic [RD_PORTS*B_W-1:0] rdb_q, rdb_d;

  logic                    idle;
  logic                    wr_acc;
  logic                    wr_ok;
  logic [RD_PORTS-1:0]     rd_acc;
  logic [RD_PORTS-1:0]     rd_oor;

  function automatic logic [A_W-1:0] rst_a(input int i);
    return A_W'(i);
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < ENT_L;
  endfunction

  assign idle   = (state_q == IDLE);
  // A clear request in the same cycle takes precedence over the write.
  assign wr_acc = wr_en_i && idle && !clr_req_i;
  assign wr_ok  = wr_acc && in_range(wr_idx_i);
  assign rd_acc = rd_en_i & {RD_PORTS{idle}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next-state table; in IDLE this is also the bypassed view seen by reads.
  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      a_d[e] = a_q[e];
      b_d[e] = b_q[e];
      if (state_q == CLEAR && cnt_q == IDX_W'(e)) begin
        a_d[e] = rst_a(e);
        b_d[e] = '0;
      end else if (wr_ok && wr_idx_i == IDX_W'(e)) begin
        if (wr_a_en_i) a_d[e] = wr_a_i;
        if (wr_b_en_i) b_d[e] = wr_b_i;
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [IDX_W-1:0]   idx;
    logic [ENTRIES-1:0] hot;
    logic [A_W-1:0]     a_or;
    logic [B_W-1:0]     b_or;

    assign idx = rd_idx_i[p*IDX_W +: IDX_W];

    // Decode is gated by acceptance, so an idle or out-of-range port ORs nothing.
    always_comb begin
      hot = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        hot[e] = rd_acc[p] && (idx == IDX_W'(e));
      end
    end

    always_comb begin
      a_or = '0;
      b_or = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        a_or = a_or | ({A_W{hot[e]}} & a_d[e]);
        b_or = b_or | ({B_W{hot[e]}} & b_d[e]);
      end
    end

    assign rd_oor[p]              = rd_acc[p] && !in_range(idx);
    assign rda_d[p*A_W +: A_W]    = a_or;
    assign rdb_d[p*B_W +: B_W]    = b_or;
  end

  assign vld_d = rd_acc;
  assign err_d = err_q | (wr_acc && !in_range(wr_idx_i)) | (|rd_oor);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        a_q[e] <= rst_a(e);
        b_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      for (int e = 0; e < ENTRIES; e++) begin
        a_q[e] <= a_d[e];
        b_q[e] <= b_d[e];
      end
    end
  end

  assign rd_valid_o = vld_q;
  assign rd_a_o     = rda_q;
  assign rd_b_o     = rdb_q;
  assign busy_o     = (state_q == CLEAR);
  assign err_o      = err_q;

endmodule

// File: tb/tb_wor_reg_table.sv
// Scoreboard bench for wor_reg_table: directed reads push expected responses,
// a negedge monitor matches them against the read ports.
module tb_wor_reg_table;
  localparam int ENTRIES = 32;
  localparam int IDX_W   = 6;
  localparam int A_W     = 5;
  localparam int B_W     = 16;
  localparam int RP      = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                wr_en, wr_a_en, wr_b_en, clr_req;
  logic [IDX_W-1:0]    wr_idx;
  logic [A_W-1:0]      wr_a;
  logic [B_W-1:0]      wr_b;
  logic [RP-1:0]       rd_en;
  logic [RP*IDX_W-1:0] rd_idx;
  logic [RP-1:0]       rd_valid;
  logic [RP*A_W-1:0]   rd_a;
  logic [RP*B_W-1:0]   rd_b;
  logic                busy, err;

  always #5 clk = ~clk;

  wor_reg_table #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .A_W(A_W), .B_W(B_W), .RD_PORTS(RP)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_a_en_i(wr_a_en), .wr_b_en_i(wr_b_en),
    .wr_a_i(wr_a), .wr_b_i(wr_b),
    .rd_en_i(rd_en), .rd_idx_i(rd_idx),
    .rd_valid_o(rd_valid), .rd_a_o(rd_a), .rd_b_o(rd_b),
    .clr_req_i(clr_req), .busy_o(busy), .err_o(err)
  );

  typedef struct {
    int             port;
    int             due;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_in();
    wr_en = 0; wr_idx = '0; wr_a_en = 0; wr_b_en = 0; wr_a = '0; wr_b = '0;
    rd_en = '0; rd_idx = '0; clr_req = 0;
  endtask

  task automatic go();
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic rd(input int p, input int idx, input logic [A_W-1:0] ea, input logic [B_W-1:0] eb);
    exp_t e;
    rd_en[p] = 1'b1;
    rd_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    e.port = p; e.due = cyc + 1; e.a = ea; e.b = eb;
    exp_q.push_back(e);
  endtask

  task automatic wr(input int idx, input bit ae, input bit be,
                    input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    wr_en = 1; wr_idx = IDX_W'(idx); wr_a_en = ae; wr_b_en = be; wr_a = a; wr_b = b;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int p = 0; p < RP; p++) begin
        int f;
        f = -1;
        foreach (exp_q[i]) if (f < 0 && exp_q[i].port == p && exp_q[i].due == cyc) f = i;
        if (rd_valid[p]) begin
          if (f < 0) begin
            chk($sformatf("unexpected_valid_p%0d", p), 64'(rd_valid[p]), 64'd0);
          end else begin
            chk($sformatf("rd_a_p%0d", p), 64'(rd_a[p*A_W +: A_W]), 64'(exp_q[f].a));
            chk($sformatf("rd_b_p%0d", p), 64'(rd_b[p*B_W +: B_W]), 64'(exp_q[f].b));
            exp_q.delete(f);
          end
        end else begin
          chk($sformatf("idle_data_p%0d", p),
              64'({rd_a[p*A_W +: A_W], rd_b[p*B_W +: B_W]}), 64'd0);
          if (f >= 0) begin
            chk($sformatf("missing_valid_p%0d", p), 64'(rd_valid[p]), 64'd1);
            exp_q.delete(f);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_in();
    reset = 1'b1;
    go(); go();
    reset = 1'b0;
    mon_on = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_a", 64'(rd_a), 64'd0);
    chk("reset_rd_b", 64'(rd_b), 64'd0);

    // Reset contents of entry 7
    rd(0, 7, 5'd7, 16'd0); go();

    // Same-cycle write/read bypass and partial field writes
    wr(3, 1, 1, 5'd20, 16'hBEEF); rd(1, 3, 5'd20, 16'hBEEF); go();
    rd(0, 3, 5'd20, 16'hBEEF); wr(4, 1, 0, 5'd20, 16'hBEEF); rd(1, 4, 5'd20, 16'd0); go();
    wr(5, 0, 1, 5'd9, 16'h1234); rd(2, 5, 5'd5, 16'h1234); rd(3, 4, 5'd20, 16'd0); go();

    // Four ports, two of them on the same entry
    wr(31, 1, 1, 5'd9, 16'hCAFE); go();
    rd(0, 0, 5'd0, 16'd0); rd(1, 31, 5'd9, 16'hCAFE);
    rd(2, 31, 5'd9, 16'hCAFE); rd(3, 16, 5'd16, 16'd0); go();

    // Out-of-range write (40 aliases 8 in the low bits) and read
    chk("err_before_oor", 64'(err), 64'd0);
    wr(40, 1, 1, 5'd1, 16'd1); rd(0, 8, 5'd8, 16'd0); go();
    chk("err_after_oor_wr", 64'(err), 64'd1);
    rd(0, 8, 5'd8, 16'd0); rd(3, 63, 5'd0, 16'd0); go();
    chk("err_sticky_1", 64'(err), 64'd1);
    go();
    chk("err_sticky_2", 64'(err), 64'd1);

    // Clear sweep; the clearing cycle's write is dropped, its read sees old data
    wr(10, 0, 1, 5'd0, 16'h1234); go();
    rd(0, 10, 5'd10, 16'h1234); go();
    clr_req = 1'b1; wr(11, 1, 1, 5'd3, 16'd3); rd(0, 10, 5'd10, 16'h1234); go();
    chk("busy_rise", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 100) begin
      wr(11, 1, 1, 5'd7, 16'd7);
      rd_en = '1;
      rd_idx = {RP{6'd10}};
      clr_req = n[0];
      n++;
      @(posedge clk); #1;
    end
    idle_in();
    chk("busy_cycles", 64'(n), 64'd32);
    rd(0, 10, 5'd10, 16'd0); rd(1, 11, 5'd11, 16'd0);
    rd(2, 3, 5'd3, 16'd0); rd(3, 31, 5'd31, 16'd0); go();
    rd(0, 5, 5'd5, 16'd0); rd(1, 4, 5'd4, 16'd0); go();
    chk("busy_after_sweep", 64'(busy), 64'd0);

    // Reset mid-sweep at counter 12
    wr(12, 1, 1, 5'd1, 16'hFFFF); go();
    wr(20, 0, 1, 5'd0, 16'hAAAA); go();
    clr_req = 1'b1; go();
    repeat (12) go();
    chk("busy_mid_sweep", 64'(busy), 64'd1);
    chk("err_before_reset", 64'(err), 64'd1);
    reset = 1'b1; go(); reset = 1'b0;
    chk("busy_after_reset", 64'(busy), 64'd0);
    chk("err_after_reset", 64'(err), 64'd0);
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < RP; p++) rd(p, k*4 + p, 5'(k*4 + p), 16'd0);
      go();
    end
    go(); go();
    chk("pending_responses", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wor_reg_table.md
WOR_REG_TABLE -- requirements
Module: wor_reg_table

Interface
REQ-001 Parameter ENTRIES, 32, number of table entries (2..256).
REQ-002 Parameter IDX_W, 5, index width; ENTRIES <= 2**IDX_W.
REQ-003 Parameter A_W, 5, width of field A.
REQ-004 Parameter B_W, 16, width of field B.
REQ-005 Parameter RD_PORTS, 2, number of independent read ports (1..4).
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_idx  in  IDX_W  write entry index.
REQ-010 wr_a_en, wr_b_en  in  1 each  per-field write enables, qualified by wr_en.
REQ-011 wr_a  in  A_W; wr_b  in  B_W  write data.
REQ-012 rd_en  in  RD_PORTS  per-port read request.
REQ-013 rd_idx  in  RD_PORTS*IDX_W  per-port read index, port p at bits [p*IDX_W +: IDX_W].
REQ-014 rd_valid  out  RD_PORTS  per-port read response valid.
REQ-015 rd_a  out  RD_PORTS*A_W; rd_b  out  RD_PORTS*B_W  per-port read data, same packing as rd_idx.
REQ-016 clr_req  in  1  request to restore all entries to reset values.
REQ-017 busy  out  1  clear sweep in progress.
REQ-018 err  out  1  sticky out-of-range index flag.

Function
REQ-019 Entry i reset value: A = i mod 2**A_W, B = 0.
REQ-020 Write: with wr_en=1, busy=0, wr_idx<ENTRIES, no clr_req, enabled fields of entry wr_idx update at the edge; disabled fields unchanged.
REQ-021 Read: rd_en[p]=1 with busy=0 is accepted; rd_valid[p]=1 exactly one cycle later with rd_a/rd_b of entry rd_idx[p]; otherwise rd_valid[p]=0.
REQ-022 rd_a/rd_b of a port SHALL be all-zero whenever its rd_valid is 0.
REQ-023 Per-port read mux SHALL be a wired-OR of per-entry fields gated by a one-hot index decode; no other entry contributes.
REQ-024 Read and write to same entry in same cycle: response carries new data for each written field, old data for unwritten fields (bypass).
REQ-025 Multiple ports reading the same entry in the same cycle all return identical data.
REQ-026 Out-of-range index (>= ENTRIES) on an accepted write: write dropped, err set next cycle.
REQ-027 Out-of-range index on an accepted read: rd_valid=1, data all-zero, err set next cycle.
REQ-028 err stays 1 until reset.
REQ-029 FSM states IDLE, CLEAR; IDLE -> CLEAR when clr_req=1; sweep counter loads 0.
REQ-030 In CLEAR, one entry per cycle (counter 0..ENTRIES-1) is restored to reset values; after entry ENTRIES-1, return to IDLE.
REQ-031 busy=1 exactly in CLEAR: rises the cycle after clr_req, falls the cycle after the last entry restored; sweep takes ENTRIES cycles.
REQ-032 In CLEAR, wr_en, rd_en and clr_req are ignored (no write, rd_valid=0, no restart, err unaffected).
REQ-033 clr_req and wr_en together in IDLE: clear wins, write dropped; accepted reads that cycle complete normally with pre-clear data.

Reset
REQ-034 reset=1 at an edge: all entries to reset values, FSM to IDLE, sweep counter 0.
REQ-035 Outputs after reset: rd_valid=0, rd_a=0, rd_b=0, busy=0, err=0.
REQ-036 Reset SHALL take priority over any write, read, or sweep in progress, including mid-clear.

Verification
REQ-037 Reset, read port0 idx 7 -> next cycle rd_valid[0]=1, rd_a=5'd7, rd_b=16'd0.
REQ-038 Write idx 3 A=5'd20 B=16'hBEEF with port1 read idx 3 same cycle -> rd_a=5'd20, rd_b=16'hBEEF next cycle; wr_b_en=0 variant -> rd_b=16'd0.
REQ-039 Write idx 40 with ENTRIES=32 -> no entry changes, err=1 next cycle and stays 1 until reset.
REQ-040 Write idx 10 B=16'h1234, pulse clr_req -> busy high 32 cycles; reads/writes in that window give rd_valid=0 and no change; afterwards idx 10 reads A=5'd10, B=0.
REQ-041 Assert reset at sweep counter 12 -> busy=0 next cycle, all entries at reset values.
REQ-042 RD_PORTS=4, all ports read idx 0/31/31/16 in one cycle -> each port returns its entry, ports 1 and 2 identical, no cross-port interference.
